// File: rtl/mod_updown_counter_pkg.sv
// Shared types and helpers for the modulo-N up/down counter.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } cnt_state_t;

  // Wide enough for any legal WIDTH (up to 16) plus the 2**WIDTH modulus.
  typedef logic [16:0] clamp_t;

  // Load values outside the count range are clamped to the top count.
  function automatic clamp_t clamp_load(input clamp_t val, input clamp_t modulus);
    return (val >= modulus) ? (modulus - clamp_t'(1)) : val;
  endfunction

  // Parameter legality: WIDTH 2..16, MODULUS 2..2**WIDTH.
  function automatic bit params_ok(input int width, input int modulus);
    return (width >= 2) && (width <= 16) && (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic             UP;
  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic             START;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             WRAP;
  logic             BUSY;

  modport master (
    output EN, UP, LOAD, LOAD_VAL, START,
    input  Q, TC, WRAP, BUSY
  );

  modport slave (
    input  EN, UP, LOAD, LOAD_VAL, START,
    output Q, TC, WRAP, BUSY
  );
endinterface

// File: rtl/mod_updown_counter_core.sv
// Count register with load clamp, modulo next-value logic and terminal detect.
module mod_counter_core
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] cnt_max = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  assign q       = q_q;
  assign at_term = up ? (q_q == cnt_max) : (q_q == '0);

  // Next count: load has priority over stepping; stepping wraps at the range ends.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = WIDTH'(clamp_load(clamp_t'(load_val), clamp_t'(MODULUS)));
    end else if (advance) begin
      if (up) q_d = (q_q == cnt_max) ? '0 : q_q + WIDTH'(1);
      else    q_d = (q_q == '0) ? cnt_max : q_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with parallel load, wrap pulse and optional one-shot run control.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int ONE_SHOT = 0
) (
  input  logic CLK,
  input  logic RST_N,
  mod_updown_counter_if.slave bus
);

  if (!params_ok(WIDTH, MODULUS)) begin : g_param_err
    $error("mod_updown_counter: illegal WIDTH/MODULUS combination");
  end

  localparam bit one_shot_mode = (ONE_SHOT != 0);

  cnt_state_t state_d, state_q;
  logic       wrap_d, wrap_q;
  logic       stepped_d, stepped_q;
  logic       counting, at_term, tc, stop, advance;

  // In one-shot mode the stop only fires once the run has stepped at least once,
  // so a restart from DONE (already at terminal) first wraps and keeps running.
  assign counting = one_shot_mode ? (state_q == RUN) : 1'b1;
  assign tc       = bus.EN & counting & at_term;
  assign stop     = one_shot_mode & tc & ~bus.LOAD & stepped_q;
  assign advance  = bus.EN & counting & ~stop;

  mod_counter_core #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_core (
    .clk      (CLK),
    .rst_n    (RST_N),
    .advance  (advance),
    .up       (bus.UP),
    .load     (bus.LOAD),
    .load_val (bus.LOAD_VAL),
    .q        (bus.Q),
    .at_term  (at_term)
  );

  assign bus.TC   = tc;
  assign bus.WRAP = wrap_q;
  assign bus.BUSY = one_shot_mode ? (state_q == RUN) : 1'b1;

  // Run-control FSM, stepped-in-run flag and wrap event.
  always_comb begin
    state_d   = state_q;
    stepped_d = 1'b0;
    wrap_d    = tc & ~bus.LOAD;
    if (one_shot_mode) begin
      case (state_q)
        IDLE:    if (bus.START) state_d = RUN;
        RUN:     if (stop)      state_d = DONE;
        DONE:    if (bus.START) state_d = RUN;
        default: state_d = IDLE;
      endcase
      stepped_d = (state_q == RUN) & (stepped_q | (bus.EN & ~bus.LOAD));
    end else begin
      state_d = IDLE;
    end
  end

  // State, flag and wrap registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      stepped_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stepped_q <= stepped_d;
      wrap_q    <= wrap_d;
    end
  end

endmodule
